// File: rtl/smash_pkg.sv
// Shared constants and types for the smash router link layer.
// Used by the link transmitter, the router and the input FIFOs.
package smash_pkg;

    localparam int unsigned FLIT_W      = 32;
    localparam int unsigned DEF_CREDITS = 2;
    localparam int unsigned PKT_CNT_W   = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } link_state_t;

    // The tail flag always sits in the top bit of a flit.
    function automatic int unsigned tail_bit(input int unsigned data_size);
        return data_size - 1;
    endfunction

endpackage

// File: rtl/smash_credit_counter.sv
// Saturating up/down credit counter with a sticky overflow flag.
// Starts full; a credit returned while already full is flagged as an error.
module smash_credit_counter #(
    parameter  int unsigned CREDITS = 2,
    localparam int unsigned CW      = $clog2(CREDITS + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_inc,
    input  logic          i_dec,
    output logic [CW-1:0] o_count,
    output logic          o_zero,
    output logic          o_err
);

    logic [CW-1:0] r_count;
    logic          r_err;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= CW'(CREDITS);
            r_err   <= 1'b0;
        end else begin
            unique case ({i_inc, i_dec})
                2'b10: begin
                    if (r_count == CW'(CREDITS)) begin
                        r_err <= 1'b1;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                2'b01: begin
                    if (r_count != '0) begin
                        r_count <= r_count - CW'(1);
                    end
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);
    assign o_err   = r_err;

endmodule

// File: rtl/smash_link_tx.sv
// Credit-based link transmitter: pops flits from the local FIFO only while
// the downstream FIFO has room, and tracks packet framing via the tail bit.
module smash_link_tx
    import smash_pkg::*;
#(
    parameter  int unsigned DATA_SIZE = FLIT_W,
    parameter  int unsigned CREDITS   = DEF_CREDITS,
    localparam int unsigned CW        = $clog2(CREDITS + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [DATA_SIZE-1:0] i_fifo_data,
    input  logic                 i_fifo_empty,
    output logic                 o_fifo_read,
    output logic [DATA_SIZE-1:0] o_link_data,
    output logic                 o_link_valid,
    input  logic                 i_link_credit,
    output logic [CW-1:0]        o_credits,
    output logic                 o_busy,
    output logic [PKT_CNT_W-1:0] o_pkt_count,
    output logic                 o_err
);

    localparam int unsigned TAIL = tail_bit(DATA_SIZE);

    logic                 w_send;
    logic                 w_tail;
    logic                 w_zero;
    link_state_t          r_state;
    link_state_t          w_next_state;
    logic [DATA_SIZE-1:0] r_link_data;
    logic                 r_link_valid;
    logic [PKT_CNT_W-1:0] r_pkt_count;

    assign w_tail      = i_fifo_data[TAIL];
    assign w_send      = !i_fifo_empty && !w_zero && !i_rst;
    assign o_fifo_read = w_send;

    smash_credit_counter #(
        .CREDITS (CREDITS)
    ) u_credit (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (i_link_credit),
        .i_dec   (w_send),
        .o_count (o_credits),
        .o_zero  (w_zero),
        .o_err   (o_err)
    );

    // Link output register: data holds between flits, valid is a per-cycle strobe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_link_data  <= '0;
            r_link_valid <= 1'b0;
        end else begin
            r_link_valid <= w_send;
            if (w_send) begin
                r_link_data <= i_fifo_data;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Packet framing: a non-tail flit opens a packet, a tail flit closes it.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_send && !w_tail) begin
                    w_next_state = ACTIVE;
                end
            end
            ACTIVE: begin
                if (w_send && w_tail) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pkt_count <= '0;
        end else if (w_send && w_tail) begin
            r_pkt_count <= r_pkt_count + PKT_CNT_W'(1);
        end
    end

    assign o_link_data  = r_link_data;
    assign o_link_valid = r_link_valid;
    assign o_busy       = (r_state == ACTIVE);
    assign o_pkt_count  = r_pkt_count;

endmodule

// File: tb/tb_smash_link_tx.sv
// Bench for smash_link_tx: directed vector table, hand sequences for the
// multi-cycle corners, then randomized traffic against a behavioural model.
module tb_smash_link_tx;

    localparam int unsigned DATA_SIZE = 32;
    localparam int unsigned CREDITS   = 2;
    localparam int unsigned CW        = $clog2(CREDITS + 1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic [DATA_SIZE-1:0] fifo_data;
    logic                 fifo_empty;
    logic                 fifo_read;
    logic [DATA_SIZE-1:0] link_data;
    logic                 link_valid;
    logic                 link_credit;
    logic [CW-1:0]        credits;
    logic                 busy;
    logic [15:0]          pkt_count;
    logic                 err;

    smash_link_tx #(
        .DATA_SIZE (DATA_SIZE),
        .CREDITS   (CREDITS)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_fifo_data   (fifo_data),
        .i_fifo_empty  (fifo_empty),
        .o_fifo_read   (fifo_read),
        .o_link_data   (link_data),
        .o_link_valid  (link_valid),
        .i_link_credit (link_credit),
        .o_credits     (credits),
        .o_busy        (busy),
        .o_pkt_count   (pkt_count),
        .o_err         (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model: credits are plain arithmetic, busy means "last flit
    // sent was not a tail", the packet count is the number of tails sent.
    int          m_cred;
    bit          m_err;
    bit          m_busy;
    int          m_pkt;
    bit          m_valid;
    logic [31:0] m_data;
    bit          m_read;

    typedef struct {
        bit          rst;
        bit          empty;
        logic [31:0] data;
        bit          credit;
        bit          exp_read;
        bit          exp_valid;
        logic [31:0] exp_data;
        int          exp_cred;
        bit          exp_busy;
        int          exp_pkt;
        bit          exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cred = CREDITS; m_err = 0; m_busy = 0; m_pkt = 0; m_valid = 0; m_data = '0;
    endtask

    function automatic bit model_send(input bit r, input bit e);
        return !r && !e && (m_cred > 0);
    endfunction

    task automatic model_clock(input bit r, input bit e, input logic [31:0] d, input bit c);
        bit s;
        s = model_send(r, e);
        if (r) begin
            model_reset();
        end else begin
            m_valid = s;
            if (s) begin
                m_data = d;
                m_busy = !d[31];
                if (d[31]) m_pkt = (m_pkt + 1) % 65536;
            end
            m_cred = m_cred + int'(c) - int'(s);
            if (m_cred > int'(CREDITS)) begin
                m_cred = CREDITS;
                m_err  = 1;
            end
        end
    endtask

    // Drive one cycle's inputs, check the pop request, clock, update the model.
    task automatic drive(input bit r, input bit e, input logic [31:0] d, input bit c);
        @(negedge clk);
        rst = r; fifo_empty = e; fifo_data = d; link_credit = c;
        #1;
        m_read = model_send(r, e);
        check("fifo_read", 32'(fifo_read), 32'(m_read));
        @(posedge clk);
        model_clock(r, e, d, c);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ":valid"}, 32'(link_valid), 32'(m_valid));
        check({tag, ":data"},  link_data, m_data);
        check({tag, ":cred"},  32'(credits), 32'(m_cred));
        check({tag, ":busy"},  32'(busy), 32'(m_busy));
        check({tag, ":pkt"},   32'(pkt_count), 32'(m_pkt));
        check({tag, ":err"},   32'(err), 32'(m_err));
    endtask

    vec_t vecs[12];

    initial begin
        logic [31:0] fa, fb, fc, fd;
        fa = 32'h0000_0011; fb = 32'h0000_0022; fc = 32'h8000_0033; fd = 32'h8000_0044;
        rst = 1; fifo_empty = 1; fifo_data = '0; link_credit = 0;
        model_reset();

        //            rst empty data credit | read valid data cred busy pkt err
        vecs[0]  = '{1, 1, 32'h0, 0,   0, 0, 32'h0, 2, 0, 0, 0};
        vecs[1]  = '{0, 0, fa,    0,   1, 1, fa,    1, 1, 0, 0};
        vecs[2]  = '{0, 0, fb,    0,   1, 1, fb,    0, 1, 0, 0};
        vecs[3]  = '{0, 0, fc,    0,   0, 0, fb,    0, 1, 0, 0};
        vecs[4]  = '{0, 0, fc,    1,   0, 0, fb,    1, 1, 0, 0};
        vecs[5]  = '{0, 0, fc,    0,   1, 1, fc,    0, 0, 1, 0};
        vecs[6]  = '{0, 1, fc,    1,   0, 0, fc,    1, 0, 1, 0};
        vecs[7]  = '{0, 1, fc,    1,   0, 0, fc,    2, 0, 1, 0};
        vecs[8]  = '{0, 1, fc,    1,   0, 0, fc,    2, 0, 1, 1};
        vecs[9]  = '{0, 1, fc,    0,   0, 0, fc,    2, 0, 1, 1};
        vecs[10] = '{0, 0, fd,    0,   1, 1, fd,    1, 0, 2, 1};
        vecs[11] = '{1, 0, fd,    0,   0, 0, 32'h0, 2, 0, 0, 0};

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rst = vecs[i].rst; fifo_empty = vecs[i].empty;
            fifo_data = vecs[i].data; link_credit = vecs[i].credit;
            #1;
            check($sformatf("v%0d:read", i), 32'(fifo_read), 32'(vecs[i].exp_read));
            @(posedge clk);
            model_clock(vecs[i].rst, vecs[i].empty, vecs[i].data, vecs[i].credit);
            #1;
            check($sformatf("v%0d:valid", i), 32'(link_valid), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d:data", i),  link_data, vecs[i].exp_data);
            check($sformatf("v%0d:cred", i),  32'(credits), 32'(vecs[i].exp_cred));
            check($sformatf("v%0d:busy", i),  32'(busy), 32'(vecs[i].exp_busy));
            check($sformatf("v%0d:pkt", i),   32'(pkt_count), 32'(vecs[i].exp_pkt));
            check($sformatf("v%0d:err", i),   32'(err), 32'(vecs[i].exp_err));
        end

        // Sustained stream with a credit returned every cycle.
        drive(1, 1, '0, 0);
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, (i == 7) ? 32'h8000_0100 : 32'h0000_0100 + 32'(i), 1);
            check("stream:cred_const", 32'(credits), 32'(CREDITS));
            check("stream:valid", 32'(link_valid), 32'd1);
            check_model("stream");
        end

        // Four single-flit packets: busy never rises.
        drive(1, 1, '0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 32'h8000_0200 + 32'(i), 1);
            check("single:busy", 32'(busy), 32'd0);
            check_model("single");
        end
        check("single:pkt4", 32'(pkt_count), 32'd4);

        // Reset pulse in the middle of a flowing packet.
        drive(0, 0, 32'h0000_0300, 1);
        drive(0, 0, 32'h0000_0301, 1);
        check("midrst:busy_before", 32'(busy), 32'd1);
        drive(1, 0, 32'h8000_0302, 1);
        check("midrst:valid", 32'(link_valid), 32'd0);
        check("midrst:cred",  32'(credits), 32'(CREDITS));
        check("midrst:busy",  32'(busy), 32'd0);
        check("midrst:pkt",   32'(pkt_count), 32'd0);
        check_model("midrst");

        // Randomized traffic with occasional resets and spurious credits.
        for (int i = 0; i < 2000; i++) begin
            bit          r, e, c;
            logic [31:0] d;
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 3) == 0);
            c = ($urandom_range(0, 2) != 0);
            d = $urandom;
            d[31] = ($urandom_range(0, 2) == 0);
            drive(r, e, d, c);
            check_model("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/smash_link_tx.md
# smash_link_tx

Credit-based link transmitter for a router output port. It drains flits from a local `smash_fifo` instance (FIFO read side) and drives one registered link toward the downstream router, whose input FIFO returns one credit per freed slot. It never sends a flit without a credit, so the downstream FIFO can never overflow. It also tracks packet framing through a tail bit, giving per-port busy status and a packet count.

## Interface
Parameters:
- `DATA_SIZE`, 32: flit width. Bit `DATA_SIZE-1` is the tail flag (1 = last flit of packet).
- `CREDITS`, 2: downstream FIFO depth and the initial credit count. Legal range is 1..255.
- `CW`, derived: `$clog2(CREDITS+1)`, the credit counter width.

Ports:
- `i_clk` input 1: the single clock. All logic is on the rising edge.
- `i_rst` input 1: synchronous reset, active-high.
- `i_fifo_data` input DATA_SIZE: head-of-FIFO flit (show-ahead).
- `i_fifo_empty` input 1: FIFO empty flag.
- `o_fifo_read` output 1: pop request. Combinational.
- `o_link_data` output DATA_SIZE: registered flit to the link.
- `o_link_valid` output 1: registered; `o_link_data` is valid this cycle.
- `i_link_credit` input 1: one-cycle pulse; the downstream router freed one slot.
- `o_credits` output CW: current credit count.
- `o_busy` output 1: a packet is in progress (head sent, tail not yet sent).
- `o_pkt_count` output 16: number of tail flits sent, wrapping.
- `o_err` output 1: sticky flag for credit overflow.

## Operation
- Send condition: `send = !i_fifo_empty && credits != 0 && !i_rst`.
  - `o_fifo_read = send`.
- On `send`:
  - `o_link_data <= i_fifo_data`.
  - `o_link_valid <= 1`.
- Otherwise:
  - `o_link_valid <= 0`.
  - `o_link_data` holds its value.
- Credit counter:
  - `send` only: count -1.
  - `i_link_credit` only: count +1.
  - Both in the same cycle: count unchanged.
- Credit overflow: `i_link_credit` arriving with count == CREDITS and no `send`:
  - count saturates at CREDITS.
  - `o_err <= 1` and stays set until reset.
- Underflow cannot occur, because `send` requires count != 0.
- FSM with two states, IDLE and ACTIVE:
  - IDLE → ACTIVE on `send` with tail = 0 (multi-flit packet head).
  - IDLE stays IDLE on `send` with tail = 1 (single-flit packet).
  - ACTIVE → IDLE on `send` with tail = 1.
  - `o_busy` is 1 in ACTIVE.
- `o_pkt_count` increments on every `send` with tail = 1 and wraps from 0xFFFF to 0.
- Payload is never inspected or modified.

## Timing
- Reset values:
  - `o_link_valid` = 0, `o_link_data` = 0.
  - credits = CREDITS.
  - state IDLE, `o_busy` = 0.
  - `o_pkt_count` = 0, `o_err` = 0.
  - `o_fifo_read` = 0 while `i_rst` is high.
- Latency: flit at FIFO head with a credit available → on the link the next cycle (1 cycle).
- Throughput: one flit per cycle while credits last.
- Credit loop: a credit pulse in cycle N enables a send in cycle N+1 (counter is registered).
- Zero credits with FIFO non-empty: `o_fifo_read` = 0 and the link is idle.
  - A credit pulse unblocks the next cycle.
- Reset mid-packet: all state returns to reset values.
  - Credits are restored to CREDITS; the system resets the downstream router with the same `i_rst`.
- `o_credits` reflects the registered count. It does not include the current cycle's `send` or credit.

## Structure
- Package `smash_pkg`:
  - `TAIL_BIT` index convention (`DATA_SIZE-1`).
  - FSM state enum `{IDLE, ACTIVE}`.
  - Default `CREDITS` and flit width constants, shared with the router and FIFO.
- Sub-module `smash_credit_counter`, parameter `CREDITS`:
  - Inputs: `i_clk`, `i_rst`, `i_inc`, `i_dec`.
  - Outputs: `o_count`, `o_zero`, `o_err`.
  - Saturating up/down counter.
- The top level holds the output register, FSM and packet counter.

## Test plan
- Reset, then FIFO holding 3 flits (tails 0,0,1), CREDITS=2, no credits returned:
  - exactly 2 flits are sent on consecutive cycles.
  - `o_credits` = 0, `o_busy` = 1, `o_fifo_read` stays 0.
- Continue from the previous scenario: pulse `i_link_credit` once:
  - third flit appears 2 cycles after the pulse.
  - `o_busy` → 0, `o_pkt_count` = 1.
- Sustained stream with a credit returned every cycle:
  - one flit per cycle.
  - `o_credits` holds constant (send and credit in the same cycle).
- Single-flit packets with tail = 1, ×4:
  - `o_busy` never asserts.
  - `o_pkt_count` = 4.
- Credit pulse with `o_credits` == CREDITS and FIFO empty:
  - count stays at CREDITS.
  - `o_err` = 1 and stays 1 until `i_rst`.
- Assert `i_rst` for 1 cycle mid-packet while flits are flowing:
  - next cycle `o_link_valid` = 0 and credits = CREDITS.
  - state IDLE, `o_pkt_count` = 0.
